// File: rtl/alu_core_pkg.sv
// Shared datapath definitions for the 8-bit ALU: bus width, op-select encoding, flag bundle.
// Purely declarative; no latency and no flow control.
package alu_core_pkg;

    localparam int BUS_W = 8;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_SUM  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_EOR  = 4'd4,
        OP_OR   = 4'd5,
        OP_SHR  = 4'd6,
        OP_ROR  = 4'd7,
        OP_LOAD = 4'd8
    } alu_op_e;

    typedef struct packed {
        logic c;
        logic z;
        logic v;
        logic n;
    } flags_t;

    // Several selects may be raised at once; the earliest in this chain wins.
    function automatic alu_op_e decode_op(
        input logic sums,
        input logic subs,
        input logic ands,
        input logic eors,
        input logic ors,
        input logic shftr,
        input logic shftcr,
        input logic load
    );
        alu_op_e op;
        if (sums)        op = OP_SUM;
        else if (subs)   op = OP_SUB;
        else if (ands)   op = OP_AND;
        else if (eors)   op = OP_EOR;
        else if (ors)    op = OP_OR;
        else if (shftr)  op = OP_SHR;
        else if (shftcr) op = OP_ROR;
        else if (load)   op = OP_LOAD;
        else             op = OP_NONE;
        return op;
    endfunction

endpackage

// File: rtl/alu_core_bcd_adjust.sv
// BCD correction of a binary add/sub result using the nibble carries (not-borrows when subtracting).
// Combinational, zero latency; no flow control.
module bcd_adjust
    import alu_core_pkg::*;
(
    input  logic [BUS_W-1:0] bin_res,
    input  logic             half_carry,
    input  logic             carry,
    input  logic             sub,
    output logic [BUS_W-1:0] dec_res,
    output logic             dec_carry
);

    logic             lo_fix;
    logic             hi_fix;
    logic [BUS_W-1:0] fix;

    always_comb begin
        if (sub) begin
            // A nibble that borrowed has wrapped by 16 instead of 10.
            lo_fix = ~half_carry;
            hi_fix = ~carry;
        end else begin
            lo_fix = half_carry || (bin_res[3:0] > 4'd9);
            hi_fix = carry || (bin_res > 8'h99);
        end
        fix       = {(hi_fix ? 4'h6 : 4'h0), (lo_fix ? 4'h6 : 4'h0)};
        dec_res   = sub ? (bin_res - fix) : (bin_res + fix);
        dec_carry = sub ? carry : hi_fix;
    end

endmodule

// File: rtl/alu_core.sv
// 8-bit ALU with registered result and C/Z/V/N flags, tri-state drivers onto ADL and SB.
// Latency: one cycle from op select to result/flags; no backpressure, an op is taken every edge.
module alu_core
    import alu_core_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic [BUS_W-1:0] a_in,
    input  logic [BUS_W-1:0] b_in,
    input  logic             cin,
    input  logic             sums,
    input  logic             subs,
    input  logic             ands,
    input  logic             eors,
    input  logic             ors,
    input  logic             shftr,
    input  logic             shftcr,
    input  logic             dec_en,
    input  logic             aluadloa,
    input  logic             alusboa,
    input  logic             aludbwa,
    input  logic [BUS_W-1:0] db,
    output logic [BUS_W-1:0] adl,
    output logic [BUS_W-1:0] sb,
    output logic             cout,
    output logic             zero,
    output logic             overflow,
    output logic             neg
);

    alu_op_e          op;
    logic [BUS_W-1:0] b_eff;
    logic [4:0]       lo_sum;
    logic [BUS_W:0]   bin_sum;
    logic [BUS_W-1:0] dec_res;
    logic             dec_carry;

    logic [BUS_W-1:0] result_d, result_q;
    flags_t           flags_d, flags_q;
    logic             upd_zn;

    assign op      = decode_op(sums, subs, ands, eors, ors, shftr, shftcr, aludbwa);
    assign b_eff   = (op == OP_SUB) ? ~b_in : b_in;
    assign lo_sum  = {1'b0, a_in[3:0]} + {1'b0, b_eff[3:0]} + {4'b0, cin};
    assign bin_sum = {1'b0, a_in} + {1'b0, b_eff} + {{BUS_W{1'b0}}, cin};

    bcd_adjust u_bcd_adjust (
        .bin_res    (bin_sum[BUS_W-1:0]),
        .half_carry (lo_sum[4]),
        .carry      (bin_sum[BUS_W]),
        .sub        (op == OP_SUB),
        .dec_res    (dec_res),
        .dec_carry  (dec_carry)
    );

    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        upd_zn   = 1'b1;
        case (op)
            OP_SUM, OP_SUB: begin
                if (dec_en) begin
                    result_d  = dec_res;
                    flags_d.c = dec_carry;
                end else begin
                    result_d  = bin_sum[BUS_W-1:0];
                    flags_d.c = bin_sum[BUS_W];
                end
                // With B inverted for subtract, one formula covers both; V tracks the binary result.
                flags_d.v = (a_in[7] == b_eff[7]) && (bin_sum[7] != a_in[7]);
            end
            OP_AND: result_d = a_in & b_in;
            OP_EOR: result_d = a_in ^ b_in;
            OP_OR:  result_d = a_in | b_in;
            OP_SHR: begin
                result_d  = {1'b0, a_in[7:1]};
                flags_d.c = a_in[0];
            end
            OP_ROR: begin
                result_d  = {cin, a_in[7:1]};
                flags_d.c = a_in[0];
            end
            OP_LOAD: begin
                result_d = db;
                upd_zn   = 1'b0;
            end
            default: upd_zn = 1'b0;
        endcase
        if (upd_zn) begin
            flags_d.z = (result_d == '0);
            flags_d.n = result_d[7];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign adl      = aluadloa ? result_q : 'z;
    assign sb       = alusboa  ? result_q : 'z;
    assign cout     = flags_q.c;
    assign zero     = flags_q.z;
    assign overflow = flags_q.v;
    assign neg      = flags_q.n;

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core; each task drives one scenario and checks inline.
module tb_alu_core;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] a_in, b_in, db;
    logic       cin, sums, subs, ands, eors, ors, shftr, shftcr, dec_en;
    logic       aluadloa, alusboa, aludbwa;
    wire  [7:0] adl, sb;
    wire        cout, zero, overflow, neg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_core dut (
        .clk      (clk),
        .clr      (clr),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin      (cin),
        .sums     (sums),
        .subs     (subs),
        .ands     (ands),
        .eors     (eors),
        .ors      (ors),
        .shftr    (shftr),
        .shftcr   (shftcr),
        .dec_en   (dec_en),
        .aluadloa (aluadloa),
        .alusboa  (alusboa),
        .aludbwa  (aludbwa),
        .db       (db),
        .adl      (adl),
        .sb       (sb),
        .cout     (cout),
        .zero     (zero),
        .overflow (overflow),
        .neg      (neg)
    );

    task automatic idle();
        clr = 0; sums = 0; subs = 0; ands = 0; eors = 0; ors = 0;
        shftr = 0; shftcr = 0; dec_en = 0; aludbwa = 0; cin = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_reset();
        idle(); alusboa = 1; aluadloa = 1; a_in = 8'h00; b_in = 8'h00; db = 8'h00;
        clr = 1; tick();
        // Load a non-zero state, then reset with an op pending: reset must win.
        a_in = 8'h50; b_in = 8'h50; sums = 1; tick();
        a_in = 8'h50; b_in = 8'h50; sums = 1; clr = 1; tick();
        total++; if (sb !== 8'h00) begin bad++; $display("FAIL reset_sb got=%h exp=00", sb); end
        total++; if (adl !== 8'h00) begin bad++; $display("FAIL reset_adl got=%h exp=00", adl); end
        total++; if ({cout, zero, overflow, neg} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000", {cout, zero, overflow, neg}); end
    endtask

    task automatic test_add();
        a_in = 8'h55; b_in = 8'h22; cin = 0; sums = 1; tick();
        total++; if (sb !== 8'h77) begin bad++; $display("FAIL add_55_22 got=%h exp=77", sb); end
        total++; if ({cout, zero, overflow, neg} !== 4'b0000) begin
            bad++; $display("FAIL add_55_22_flags got=%b exp=0000", {cout, zero, overflow, neg}); end
        alusboa = 0; aluadloa = 0; #1;
        total++; if (sb === 8'h77) begin bad++; $display("FAIL sb_disabled got=%h exp=not 77", sb); end
        total++; if (adl === 8'h77) begin bad++; $display("FAIL adl_disabled got=%h exp=not 77", adl); end
        alusboa = 1;
        a_in = 8'h50; b_in = 8'h50; sums = 1; tick();
        total++; if (sb !== 8'hA0) begin bad++; $display("FAIL add_50_50 got=%h exp=a0", sb); end
        total++; if ({cout, zero, overflow, neg} !== 4'b0011) begin
            bad++; $display("FAIL add_50_50_flags got=%b exp=0011", {cout, zero, overflow, neg}); end
        a_in = 8'hFF; b_in = 8'h01; sums = 1; tick();
        total++; if (sb !== 8'h00) begin bad++; $display("FAIL add_ff_01 got=%h exp=00", sb); end
        total++; if ({cout, zero, overflow, neg} !== 4'b1100) begin
            bad++; $display("FAIL add_ff_01_flags got=%b exp=1100", {cout, zero, overflow, neg}); end
    endtask

    task automatic test_sub();
        a_in = 8'h10; b_in = 8'h20; cin = 1; subs = 1; tick();
        total++; if (sb !== 8'hF0) begin bad++; $display("FAIL sub_10_20 got=%h exp=f0", sb); end
        total++; if ({cout, zero, overflow, neg} !== 4'b0001) begin
            bad++; $display("FAIL sub_10_20_flags got=%b exp=0001", {cout, zero, overflow, neg}); end
        a_in = 8'h80; b_in = 8'h01; cin = 1; subs = 1; tick();
        total++; if (sb !== 8'h7F) begin bad++; $display("FAIL sub_80_01 got=%h exp=7f", sb); end
        total++; if ({cout, zero, overflow, neg} !== 4'b1010) begin
            bad++; $display("FAIL sub_80_01_flags got=%b exp=1010", {cout, zero, overflow, neg}); end
    endtask

    task automatic test_bcd();
        a_in = 8'h19; b_in = 8'h28; cin = 0; dec_en = 1; sums = 1; tick();
        total++; if (sb !== 8'h47) begin bad++; $display("FAIL bcd_add_19_28 got=%h exp=47", sb); end
        total++; if ({cout, zero, overflow, neg} !== 4'b0000) begin
            bad++; $display("FAIL bcd_add_19_28_flags got=%b exp=0000", {cout, zero, overflow, neg}); end
        a_in = 8'h99; b_in = 8'h01; cin = 0; dec_en = 1; sums = 1; tick();
        total++; if (sb !== 8'h00) begin bad++; $display("FAIL bcd_add_99_01 got=%h exp=00", sb); end
        total++; if ({cout, zero, overflow, neg} !== 4'b1100) begin
            bad++; $display("FAIL bcd_add_99_01_flags got=%b exp=1100", {cout, zero, overflow, neg}); end
        a_in = 8'h20; b_in = 8'h01; cin = 1; dec_en = 1; subs = 1; tick();
        total++; if (sb !== 8'h19) begin bad++; $display("FAIL bcd_sub_20_01 got=%h exp=19", sb); end
        total++; if ({cout, zero, overflow, neg} !== 4'b1000) begin
            bad++; $display("FAIL bcd_sub_20_01_flags got=%b exp=1000", {cout, zero, overflow, neg}); end
        a_in = 8'h10; b_in = 8'h20; cin = 1; dec_en = 1; subs = 1; tick();
        total++; if (sb !== 8'h90) begin bad++; $display("FAIL bcd_sub_10_20 got=%h exp=90", sb); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL bcd_sub_10_20_c got=%b exp=0", cout); end
    endtask

    task automatic test_shift();
        a_in = 8'h01; cin = 1; shftcr = 1; tick();
        total++; if (sb !== 8'h80) begin bad++; $display("FAIL ror_01 got=%h exp=80", sb); end
        total++; if ({cout, zero, overflow, neg} !== 4'b1001) begin
            bad++; $display("FAIL ror_01_flags got=%b exp=1001", {cout, zero, overflow, neg}); end
        a_in = 8'h01; cin = 1; shftr = 1; tick();
        total++; if (sb !== 8'h00) begin bad++; $display("FAIL shr_01 got=%h exp=00", sb); end
        total++; if ({cout, zero, overflow, neg} !== 4'b1100) begin
            bad++; $display("FAIL shr_01_flags got=%b exp=1100", {cout, zero, overflow, neg}); end
        // Overflow must survive a shift.
        a_in = 8'h50; b_in = 8'h50; sums = 1; tick();
        a_in = 8'h02; shftr = 1; tick();
        total++; if (sb !== 8'h01) begin bad++; $display("FAIL shr_02 got=%h exp=01", sb); end
        total++; if ({cout, zero, overflow, neg} !== 4'b0010) begin
            bad++; $display("FAIL shr_02_flags got=%b exp=0010", {cout, zero, overflow, neg}); end
    endtask

    task automatic test_logic();
        a_in = 8'h80; b_in = 8'h80; sums = 1; tick();
        total++; if ({cout, zero, overflow, neg} !== 4'b1110) begin
            bad++; $display("FAIL add_80_80_flags got=%b exp=1110", {cout, zero, overflow, neg}); end
        a_in = 8'hF0; b_in = 8'h3C; ands = 1; tick();
        total++; if (sb !== 8'h30) begin bad++; $display("FAIL and got=%h exp=30", sb); end
        total++; if ({cout, zero, overflow, neg} !== 4'b1010) begin
            bad++; $display("FAIL and_flags got=%b exp=1010", {cout, zero, overflow, neg}); end
        a_in = 8'h0F; b_in = 8'hF0; ands = 1; tick();
        total++; if ({cout, zero, overflow, neg} !== 4'b1110) begin
            bad++; $display("FAIL and_zero_flags got=%b exp=1110", {cout, zero, overflow, neg}); end
        a_in = 8'hF0; b_in = 8'h3C; eors = 1; tick();
        total++; if (sb !== 8'hCC) begin bad++; $display("FAIL eor got=%h exp=cc", sb); end
        a_in = 8'h0F; b_in = 8'hF0; ors = 1; tick();
        total++; if (sb !== 8'hFF) begin bad++; $display("FAIL or got=%h exp=ff", sb); end
        total++; if ({cout, zero, overflow, neg} !== 4'b1011) begin
            bad++; $display("FAIL or_flags got=%b exp=1011", {cout, zero, overflow, neg}); end
    endtask

    task automatic test_load_and_priority();
        alusboa = 0; aluadloa = 1; db = 8'h3C; aludbwa = 1; tick();
        total++; if (adl !== 8'h3C) begin bad++; $display("FAIL load_db got=%h exp=3c", adl); end
        total++; if ({cout, zero, overflow, neg} !== 4'b1011) begin
            bad++; $display("FAIL load_db_flags got=%b exp=1011", {cout, zero, overflow, neg}); end
        alusboa = 1; #1;
        total++; if (sb !== adl || sb !== 8'h3C) begin
            bad++; $display("FAIL both_enables sb=%h adl=%h exp=3c", sb, adl); end
        a_in = 8'h55; b_in = 8'h22; sums = 1; ands = 1; aludbwa = 1; tick();
        total++; if (sb !== 8'h77) begin bad++; $display("FAIL prio_sum_and got=%h exp=77", sb); end
        a_in = 8'h81; b_in = 8'h00; ors = 1; shftr = 1; tick();
        total++; if (sb !== 8'h81) begin bad++; $display("FAIL prio_or_shr got=%h exp=81", sb); end
        a_in = 8'h10; b_in = 8'h01; cin = 1; subs = 1; eors = 1; tick();
        total++; if (sb !== 8'h0F) begin bad++; $display("FAIL prio_sub_eor got=%h exp=0f", sb); end
    endtask

    task automatic test_hold_and_sampling();
        a_in = 8'h12; b_in = 8'h34; tick();
        total++; if (sb !== 8'h0F) begin bad++; $display("FAIL hold_result got=%h exp=0f", sb); end
        total++; if ({cout, zero, overflow, neg} !== 4'b1000) begin
            bad++; $display("FAIL hold_flags got=%b exp=1000", {cout, zero, overflow, neg}); end
        // Operands wiggle mid-cycle; only the value present at the edge counts.
        a_in = 8'hEE; b_in = 8'h01; sums = 1;
        #2 a_in = 8'h11;
        #2 a_in = 8'h20;
        tick();
        total++; if (sb !== 8'h21) begin bad++; $display("FAIL sample_at_edge got=%h exp=21", sb); end
    endtask

    initial begin
        idle(); alusboa = 0; aluadloa = 0; a_in = 0; b_in = 0; db = 0;
        test_reset();
        test_add();
        test_sub();
        test_bcd();
        test_shift();
        test_logic();
        test_load_and_priority();
        test_hold_and_sampling();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
